tns_enc_09_seq: RTL

- Sequential TNS encoder that sits directly upstream of the 9-bit TNS decoder.
- Converts a binary data word into a 9-bit TNS codeword: three 3-bit groups with weights TNS03_A..TNS01_C.
- Uses greedy successive subtraction, resolving one digit per cycle, MSB first.
- Valid/ready handshake on both sides; its codeword is what the decoder consumes after the link.

---
 rtl/tns_enc_09_seq_pkg.sv | 45 ++++
 rtl/TNS_dec_09.sv | 20 ++
 rtl/tns_weight_sel.sv | 15 +
 rtl/tns_enc_09_seq.sv | 135 +++++++++++++
 4 files changed

// File: rtl/tns_enc_09_seq_pkg.sv
// Shared TNS definitions: digit weights, data width, weight sum and encoder states.
package tns_enc_09_seq_pkg;

  localparam int unsigned TNS01_C = 1;
  localparam int unsigned TNS01_B = 2;
  localparam int unsigned TNS01_A = 4;
  localparam int unsigned TNS02_C = 7;
  localparam int unsigned TNS02_B = 13;
  localparam int unsigned TNS02_A = 24;
  localparam int unsigned TNS03_C = 44;
  localparam int unsigned TNS03_B = 81;
  localparam int unsigned TNS03_A = 149;

  localparam int unsigned TNS_WMAX09 = TNS01_C + TNS01_B + TNS01_A
                                     + TNS02_C + TNS02_B + TNS02_A
                                     + TNS03_C + TNS03_B + TNS03_A;

  // Wide enough for WMAX so the full range is encodable.
  localparam int unsigned BLEN03 = $clog2(TNS_WMAX09 + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } tns_state_e;

  // Weight of codeword digit idx; bit 8 is the heaviest, unused indices weigh 0.
  function automatic int unsigned tns_weight(input logic [3:0] idx);
    int unsigned w;
    case (idx)
      4'd8:    w = TNS03_A;
      4'd7:    w = TNS03_B;
      4'd6:    w = TNS03_C;
      4'd5:    w = TNS02_A;
      4'd4:    w = TNS02_B;
      4'd3:    w = TNS02_C;
      4'd2:    w = TNS01_A;
      4'd1:    w = TNS01_B;
      4'd0:    w = TNS01_C;
      default: w = 0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/TNS_dec_09.sv
// 9-digit TNS decoder: sums the weights of all set codeword bits.
module TNS_dec_09
  import tns_enc_09_seq_pkg::*;
#(
  parameter int unsigned DATA_W = BLEN03
) (
  input  logic [8:0]        codein,
  output logic [DATA_W-1:0] dataout
);

  always_comb begin
    dataout = '0;
    for (int i = 0; i < 9; i++) begin
      if (codein[i]) begin
        dataout = dataout + DATA_W'(tns_weight(4'(i)));
      end
    end
  end

endmodule

// File: rtl/tns_weight_sel.sv
// Combinational digit-index to weight mux, shared by TNS encoders of any width.
module tns_weight_sel
  import tns_enc_09_seq_pkg::*;
#(
  parameter int unsigned DATA_W = BLEN03
) (
  input  logic [3:0]        idx,
  output logic [DATA_W-1:0] weight
);

  always_comb begin
    weight = DATA_W'(tns_weight(idx));
  end

endmodule

// File: rtl/tns_enc_09_seq.sv
// Sequential 9-digit TNS encoder, greedy MSB-first, one digit per cycle.
// Define TNS_ENC_CHECK_EN to add a decode-back self-check driving chk_err.
module tns_enc_09_seq
  import tns_enc_09_seq_pkg::*;
#(
  parameter int unsigned DATA_W = BLEN03,
  parameter int unsigned NDIG   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] datain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8:0]        codeout,
  output logic              code_err,
  output logic              chk_err
);

  if (NDIG != 9) begin : g_ndig_check
    $error("tns_enc_09_seq: NDIG must be 9");
  end

  tns_state_e        state_q, state_d;
  logic [DATA_W-1:0] residue_q;
  logic [3:0]        idx_q;
  logic [8:0]        code_q;
  logic              err_q;

  logic [DATA_W-1:0] weight;
  logic              take;
  logic [DATA_W-1:0] residue_nxt;
  logic [8:0]        code_nxt;
  logic              accept;

  tns_weight_sel #(
    .DATA_W (DATA_W)
  ) u_weight_sel (
    .idx    (idx_q),
    .weight (weight)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StBusy;
      StBusy:  if (idx_q == 4'd0) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  assign accept = in_valid && in_ready;

  // One greedy step: subtract only when it cannot underflow.
  always_comb begin
    take        = (residue_q >= weight);
    residue_nxt = take ? (residue_q - weight) : residue_q;
    code_nxt    = code_q;
    code_nxt[idx_q] = take;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      residue_q <= '0;
      idx_q     <= 4'd8;
      code_q    <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      residue_q <= datain;
      idx_q     <= 4'd8;
      code_q    <= '0;
      err_q     <= 1'b0;
    end else if (state_q == StBusy) begin
      residue_q <= residue_nxt;
      code_q    <= code_nxt;
      if (idx_q != 4'd0) begin
        idx_q <= idx_q - 4'd1;
      end else begin
        err_q <= (residue_nxt != '0);
      end
    end
  end

  assign codeout  = code_q;
  assign code_err = err_q;

`ifdef TNS_ENC_CHECK_EN
  logic [DATA_W-1:0] cap_q;
  logic [DATA_W-1:0] decoded;
  logic              chk_q;

  // Decode the codeword as it will be registered on the final BUSY edge.
  TNS_dec_09 #(
    .DATA_W (DATA_W)
  ) u_dec (
    .codein  (code_nxt),
    .dataout (decoded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
      chk_q <= 1'b0;
    end else if (accept) begin
      cap_q <= datain;
      chk_q <= 1'b0;
    end else if (state_q == StBusy && idx_q == 4'd0) begin
      chk_q <= (decoded != cap_q) && (residue_nxt == '0);
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule
